// File: rtl/unpack_mod_ot_n_pkg.sv
// Shared definitions for the oblivious-transfer unpack engine:
// FSM state encoding, default sizing and the request latency helper.
package unpack_pkg;

  // Default operand width and number of candidate messages
  localparam int DEF_WIDTH   = 32;
  localparam int DEF_NUM_MSG = 2;

  // Unpack FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RED_K = 3'd1,
    ST_RED_M = 3'd2,
    ST_SUB   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Cycle index of the done pulse, counted with the accepting edge as cycle 0
  function automatic int unsigned unpack_latency(input int unsigned width);
    return (32'd2 * width) + 32'd2;
  endfunction

endpackage

// File: rtl/unpack_mod_ot_n_if.sv
// Request/response bundle of the unpack engine. The requester uses the
// master modport, the engine uses the slave modport.
interface unpack_mod_ot_n_if
  import unpack_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_MSG = DEF_NUM_MSG,
  parameter int SEL_W   = $clog2(NUM_MSG)
);
  logic                     start;
  logic [SEL_W-1:0]         sel;
  logic [NUM_MSG*WIDTH-1:0] messages;
  logic [WIDTH-1:0]         N;
  logic [WIDTH-1:0]         rand_val;
  logic                     busy;
  logic                     done;
  logic [WIDTH-1:0]         result;
  logic                     err;

  modport master (
    output start, sel, messages, N, rand_val,
    input  busy, done, result, err
  );

  modport slave (
    input  start, sel, messages, N, rand_val,
    output busy, done, result, err
  );
endinterface

// File: rtl/unpack_mod_ot_n_mod_reduce_serial.sv
// Bit-serial modular reducer: r = x mod n, shift-subtract MSB first over a
// WIDTH+1-bit remainder. The go edge loads the operand and performs the
// first step; rdy pulses once the last of the WIDTH steps has been applied.
// With n == 0 every step subtracts zero, so r returns x unchanged.
module mod_reduce_serial #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             go,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] r,
  output logic             rdy
);
  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] n_q;
  logic [CW-1:0]    cnt_q;
  logic             act_q;
  logic             rdy_q;

  // One shift-subtract step: bring in the next operand bit, subtract n if it fits
  function automatic logic [WIDTH:0] red_step(input logic [WIDTH:0] rem,
                                              input logic bit_in,
                                              input logic [WIDTH-1:0] modn);
    logic [WIDTH:0] t;
    logic [WIDTH:0] d;
    t = (rem << 1) | {{WIDTH{1'b0}}, bit_in};
    d = t - {1'b0, modn};
    if (t >= {1'b0, modn}) begin
      return d;
    end else begin
      return t;
    end
  endfunction

  // Load on go, then step once per cycle until WIDTH bits have been consumed
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_q   <= '0;
      sh_q  <= '0;
      n_q   <= '0;
      cnt_q <= '0;
      act_q <= 1'b0;
      rdy_q <= 1'b0;
    end else if (go) begin
      r_q   <= red_step({(WIDTH+1){1'b0}}, x[WIDTH-1], n);
      sh_q  <= {x[WIDTH-2:0], 1'b0};
      n_q   <= n;
      cnt_q <= CW'(1);
      act_q <= 1'b1;
      rdy_q <= 1'b0;
    end else if (act_q) begin
      r_q   <= red_step(r_q, sh_q[WIDTH-1], n_q);
      sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) begin
        act_q <= 1'b0;
        rdy_q <= 1'b1;
      end else begin
        act_q <= 1'b1;
        rdy_q <= 1'b0;
      end
    end else begin
      rdy_q <= 1'b0;
    end
  end

  assign r   = r_q[WIDTH-1:0];
  assign rdy = rdy_q;

endmodule

// File: rtl/unpack_mod_ot_n.sv
// Receiver-side unpack for 1-out-of-NUM_MSG oblivious transfer:
// result = (m'_sel - (rand_val mod N)) mod N, using one serial reducer twice.
// Optional input checking is enabled with the UNPACK_ERR_CHECK_EN macro.
module unpack_mod_ot_n
  import unpack_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int NUM_MSG = DEF_NUM_MSG,
  parameter int SEL_W   = $clog2(NUM_MSG)
) (
  input  logic              clk,
  input  logic              rstn,
  unpack_mod_ot_n_if.slave  bus
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] msg_q, msg_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             red_go_s;
  logic [WIDTH-1:0] red_x_s;
  logic [WIDTH-1:0] red_n_s;
  logic [WIDTH-1:0] red_r_s;
  logic             red_rdy_s;

  logic [SEL_W:0]   sel_idx_s;
  logic [WIDTH-1:0] sel_msg_s;
  logic             in_err_s;
  logic [WIDTH:0]   diff_s;

  // Pick the requested message; an out-of-range selector wraps modulo NUM_MSG
  always_comb begin
    sel_idx_s = {1'b0, bus.sel};
    if (sel_idx_s >= (SEL_W+1)'(NUM_MSG)) begin
      sel_idx_s = sel_idx_s - (SEL_W+1)'(NUM_MSG);
    end else begin
      sel_idx_s = {1'b0, bus.sel};
    end
    sel_msg_s = bus.messages[int'(sel_idx_s) * WIDTH +: WIDTH];
  end

`ifdef UNPACK_ERR_CHECK_EN
  assign in_err_s = (bus.N == '0) || ({1'b0, bus.sel} >= (SEL_W+1)'(NUM_MSG));
`else
  assign in_err_s = 1'b0;
`endif

  // Final correction: m - k, adding N back when k exceeds m
  always_comb begin
    diff_s = {1'b0, red_r_s} - {1'b0, k_q};
    if (red_r_s < k_q) begin
      diff_s = diff_s + {1'b0, n_q};
    end else begin
      diff_s = diff_s + (WIDTH+1)'(0);
    end
  end

  mod_reduce_serial #(.WIDTH(WIDTH)) u_red (
    .clk  (clk),
    .rstn (rstn),
    .go   (red_go_s),
    .x    (red_x_s),
    .n    (red_n_s),
    .r    (red_r_s),
    .rdy  (red_rdy_s)
  );

  // Next-state and register updates for the unpack sequence
  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    msg_d    = msg_q;
    k_d      = k_q;
    result_d = result_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    red_go_s = 1'b0;
    red_x_s  = msg_q;
    red_n_s  = n_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          n_d      = bus.N;
          msg_d    = sel_msg_s;
          result_d = '0;
          err_d    = in_err_s;
          busy_d   = 1'b1;
          if (in_err_s) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_RED_K;
            red_go_s = 1'b1;
            red_x_s  = bus.rand_val;
            red_n_s  = bus.N;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RED_K: begin
        if (red_rdy_s) begin
          k_d      = red_r_s;
          red_go_s = 1'b1;
          state_d  = ST_RED_M;
        end else begin
          state_d = ST_RED_K;
        end
      end
      ST_RED_M: begin
        if (red_rdy_s) begin
          state_d = ST_SUB;
        end else begin
          state_d = ST_RED_M;
        end
      end
      ST_SUB: begin
        result_d = diff_s[WIDTH-1:0];
        done_d   = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      n_q      <= '0;
      msg_q    <= '0;
      k_q      <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      msg_q    <= msg_d;
      k_q      <= k_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_unpack_mod_ot_n.sv
// Directed bench for unpack_mod_ot_n: a two-message and a four-message
// instance share the clock and reset; expected values are hand computed.
module tb_unpack_mod_ot_n;
  import unpack_pkg::*;

  localparam int W = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  unpack_mod_ot_n_if #(.WIDTH(W), .NUM_MSG(2)) if2 ();
  unpack_mod_ot_n_if #(.WIDTH(W), .NUM_MSG(4)) if4 ();

  unpack_mod_ot_n #(.WIDTH(W), .NUM_MSG(2)) dut2 (.clk(clk), .rstn(rstn), .bus(if2.slave));
  unpack_mod_ot_n #(.WIDTH(W), .NUM_MSG(4)) dut4 (.clk(clk), .rstn(rstn), .bus(if4.slave));

  logic           start2 = 1'b0;
  logic           start4 = 1'b0;
  logic [1:0]     sel_v  = 2'd0;
  logic [4*W-1:0] msgs_v = '0;
  logic [W-1:0]   n_v    = '0;
  logic [W-1:0]   rv_v   = '0;
  logic           use4_v = 1'b0;

  assign if2.start    = start2;
  assign if2.sel      = sel_v[0];
  assign if2.messages = msgs_v[2*W-1:0];
  assign if2.N        = n_v;
  assign if2.rand_val = rv_v;
  assign if4.start    = start4;
  assign if4.sel      = sel_v;
  assign if4.messages = msgs_v;
  assign if4.N        = n_v;
  assign if4.rand_val = rv_v;

  logic         done_s, busy_s, err_s;
  logic [W-1:0] result_s;
  assign done_s   = use4_v ? if4.done   : if2.done;
  assign busy_s   = use4_v ? if4.busy   : if2.busy;
  assign err_s    = use4_v ? if4.err    : if2.err;
  assign result_s = use4_v ? if4.result : if2.result;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         u4;
    logic [1:0]   sel;
    logic [W-1:0] m0, m1, m2, m3;
    logic [W-1:0] n, rv;
    logic [W-1:0] exp_res;
    logic         exp_err;
    int           exp_cyc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request and wait for its done pulse. cyc is the done cycle with
  // the accepting edge as cycle 0 (-1 on timeout). When glitch > 0, a second
  // start with different operands is pulsed in that cycle.
  task automatic do_req(input logic u4, input logic [1:0] s,
                        input logic [W-1:0] m0, input logic [W-1:0] m1,
                        input logic [W-1:0] m2, input logic [W-1:0] m3,
                        input logic [W-1:0] n, input logic [W-1:0] rv,
                        input int glitch,
                        output int cyc, output logic [W-1:0] res,
                        output logic e, output logic b1);
    int k;
    use4_v = u4;
    @(negedge clk);
    k = 0;
    while (busy_s && k < 300) begin
      @(negedge clk);
      k++;
    end
    sel_v  = s;
    msgs_v = {m3, m2, m1, m0};
    n_v    = n;
    rv_v   = rv;
    if (u4) start4 = 1'b1; else start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    start4 = 1'b0;
    b1  = busy_s;
    cyc = -1;
    res = '0;
    e   = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done_s) begin
        cyc = i + 1;
        res = result_s;
        e   = err_s;
        break;
      end
      if (glitch > 0 && i + 1 == glitch) begin
        sel_v  = 2'd0;
        msgs_v = {4{32'h5555_5555}};
        n_v    = 32'd5;
        rv_v   = 32'd3;
        if (u4) start4 = 1'b1; else start2 = 1'b1;
      end
      @(posedge clk);
      #1;
      start2 = 1'b0;
      start4 = 1'b0;
    end
  endtask

  initial begin
    int           cyc;
    int           lat;
    int           npulse;
    logic [W-1:0] res;
    logic         e, b1;

    lat = int'(unpack_latency(W));

    vecs[0] = '{1'b0, 2'd1, 32'd11,  32'd50, 32'd0, 32'd0, 32'd97, 32'd200, 32'd44, 1'b0, lat};
    vecs[1] = '{1'b0, 2'd0, 32'd3,   32'd0,  32'd0, 32'd0, 32'd97, 32'd10,  32'd90, 1'b0, lat};
    vecs[2] = '{1'b0, 2'd0, 32'd40,  32'd0,  32'd0, 32'd0, 32'd97, 32'd40,  32'd0,  1'b0, lat};
    vecs[3] = '{1'b0, 2'd1, 32'd0,   32'd2,  32'd0, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF,
                32'hFFFF_FFF9, 1'b0, lat};
    vecs[4] = '{1'b0, 2'd0, 32'd200, 32'd0,  32'd0, 32'd0, 32'd97, 32'd5,   32'd1,  1'b0, lat};
    vecs[5] = '{1'b1, 2'd0, 32'd999, 32'd0,  32'd0, 32'd0, 32'd1000, 32'd12345, 32'd654, 1'b0, lat};
    vecs[6] = '{1'b1, 2'd2, 32'd5,   32'd6,  32'd7, 32'd8, 32'd13, 32'd1,   32'd6,  1'b0, lat};
`ifdef UNPACK_ERR_CHECK_EN
    vecs[7] = '{1'b0, 2'd0, 32'd5,   32'd0,  32'd0, 32'd0, 32'd0,  32'd9,   32'd0,  1'b1, 1};
`else
    vecs[7] = '{1'b0, 2'd0, 32'd5,   32'd0,  32'd0, 32'd0, 32'd0,  32'd9,   32'hFFFF_FFFC, 1'b0, lat};
`endif

    // Reset state of both instances
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy2",   W'(if2.busy),  W'(0));
    chk("rst_done2",   W'(if2.done),  W'(0));
    chk("rst_result2", if2.result,    W'(0));
    chk("rst_err2",    W'(if2.err),   W'(0));
    chk("rst_busy4",   W'(if4.busy),  W'(0));
    chk("rst_done4",   W'(if4.done),  W'(0));
    chk("rst_result4", if4.result,    W'(0));
    chk("rst_err4",    W'(if4.err),   W'(0));
    rstn = 1'b1;

    // Table-driven requests
    for (int v = 0; v < 8; v++) begin
      do_req(vecs[v].u4, vecs[v].sel, vecs[v].m0, vecs[v].m1, vecs[v].m2, vecs[v].m3,
             vecs[v].n, vecs[v].rv, 0, cyc, res, e, b1);
      chk($sformatf("vec%0d_result", v), res, vecs[v].exp_res);
      chk($sformatf("vec%0d_err", v), W'(e), W'(vecs[v].exp_err));
      chk($sformatf("vec%0d_done_cycle", v), W'(cyc), W'(vecs[v].exp_cyc));
      chk($sformatf("vec%0d_busy_c1", v), W'(b1), W'(1));
    end

    // Four-way select with an ignored start and changed inputs in cycle 10
    do_req(1'b1, 2'd3, 32'd5, 32'd6, 32'd7, 32'd8, 32'd13, 32'd1, 10, cyc, res, e, b1);
    chk("glitch_result",     res,     W'(7));
    chk("glitch_err",        W'(e),   W'(0));
    chk("glitch_done_cycle", W'(cyc), W'(lat));
    @(posedge clk);
    #1;
    chk("post_done_pulse", W'(if4.done), W'(0));
    chk("post_busy",       W'(if4.busy), W'(0));
    repeat (5) @(posedge clk);
    #1;
    chk("post_result_held", if4.result, W'(7));

    // Reset in cycle 20 of a running request
    use4_v = 1'b0;
    @(negedge clk);
    sel_v  = 2'd1;
    msgs_v = {32'd0, 32'd0, 32'd50, 32'd11};
    n_v    = 32'd97;
    rv_v   = 32'd200;
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("midrst_busy",   W'(if2.busy), W'(0));
    chk("midrst_done",   W'(if2.done), W'(0));
    chk("midrst_result", if2.result,   W'(0));
    chk("midrst_err",    W'(if2.err),  W'(0));
    npulse = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (if2.done) npulse++;
    end
    chk("midrst_no_done", W'(npulse), W'(0));

    do_req(1'b0, 2'd1, 32'd11, 32'd50, 32'd0, 32'd0, 32'd97, 32'd200, 0, cyc, res, e, b1);
    chk("fresh_result",     res,     W'(44));
    chk("fresh_err",        W'(e),   W'(0));
    chk("fresh_done_cycle", W'(cyc), W'(lat));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/unpack_mod_ot_n.md
# unpack_mod_ot_n

Receiver-side unpack engine for 1-out-of-NUM_MSG oblivious transfer. It computes m_sel = (m'_sel − (rand_val mod N)) mod N over a parametrised word width. It replaces the fixed 32-bit, two-message unpack stage, adding a valid/done handshake, a held result and input error flagging. Modular reduction runs on an internal bit-serial reducer instead of a shared exponentiation core, because the exponent is always 1.

## Interface
Parameters:
- WIDTH, 32: operand/modulus width in bits (≥ 2)
- NUM_MSG, 2: number of candidate messages (≥ 2)
- SEL_W, $clog2(NUM_MSG): selector width (derived; do not override)

Ports:
- clk  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- start  in  1  request pulse; accepted only in IDLE
- sel  in  SEL_W  index of the message to unpack
- messages  in  NUM_MSG*WIDTH  packed messages; message i = messages[i*WIDTH +: WIDTH]
- N  in  WIDTH  modulus
- rand_val  in  WIDTH  receiver key k before reduction
- busy  out  1  high from the cycle after accept through the DONE cycle
- done  out  1  one-cycle pulse; result valid
- result  out  WIDTH  unpacked message; holds until the next accept
- err  out  1  valid with done; high when inputs were illegal

## Operation
- FSM states: IDLE, RED_K, RED_M, SUB, DONE.
- IDLE, start=1:
  - capture N, rand_val and messages[sel] into registers.
  - clear result and err.
  - go to RED_K.
- RED_K: reduce k = rand_val mod N on the reducer; go to RED_M when the reducer finishes.
- RED_M: reduce m = m'_sel mod N (the message may be ≥ N); go to SUB.
- SUB:
  - if m ≥ k, result = m − k; else result = m − k + N.
  - compute in WIDTH+1 bits, keep the low WIDTH bits.
  - m == k gives 0.
- DONE: done=1, busy=1; next cycle go to IDLE.
- Reducer algorithm: shift-subtract, MSB first, over a WIDTH+1-bit remainder r.
  - Each cycle: r = (r<<1)|bit; if r ≥ N then r −= N.
  - Takes exactly WIDTH cycles.
  - With N == 0 it returns the operand unchanged.
- start while busy: ignored, with no effect on captured operands.
- Captured operands are used throughout; input changes after accept have no effect.
- Reset, including mid-operation: state=IDLE; busy=0, done=0, err=0, result=0. No done pulse is emitted for an aborted request.

## Timing
- Accept at clock edge 0 (start=1 sampled in IDLE).
- RED_K occupies cycles 1..WIDTH; RED_M occupies WIDTH+1..2·WIDTH; SUB is cycle 2·WIDTH+1.
- done=1 in cycle 2·WIDTH+2 only. WIDTH=32 gives done at cycle 66.
- IDLE is re-entered at cycle 2·WIDTH+3; the earliest next accept is that edge. Throughput is one request per 2·WIDTH+3 cycles.
- result and err become valid in the done cycle and stay stable until the next accepted start.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- UNPACK_ERR_CHECK_EN defined:
  - At accept, err is set if N == 0 or sel ≥ NUM_MSG.
  - On err the FSM skips to DONE at cycle 1, with result=0 and done at cycle 1.
- UNPACK_ERR_CHECK_EN undefined:
  - err is tied 0.
  - sel ≥ NUM_MSG selects message (sel mod NUM_MSG).
  - N == 0 runs the full latency and yields (m' − rand_val) mod 2^WIDTH.

## Structure
- Shared package unpack_pkg:
  - FSM state encoding (3-bit typedef).
  - Default WIDTH and NUM_MSG constants.
  - A function for the latency 2·WIDTH+2, used by the bench.
- Sub-module mod_reduce_serial:
  - Parameters: WIDTH.
  - Ports: clk, rstn, go, x, n, r, rdy.
  - One instance, reused for both reductions.
  - rdy pulses in cycle WIDTH after go.

## Test plan
- Basic unpack:
  - Stimulus: WIDTH=32, NUM_MSG=2, N=97, rand_val=200 (k=6), messages={m0=11, m1=50}, sel=1.
  - Expect: result=44, err=0, done at cycle 66.
- Wrap-around and equality:
  - Stimulus: N=97, rand_val=10, m'=3.
  - Expect: result=90.
  - Repeat with rand_val=m'=40; expect result=0.
- Oversized operands:
  - Stimulus: N=0xFFFFFFFB, rand_val=0xFFFFFFFF, m'=2.
  - Expect: k=4, result=0xFFFFFFF9.
- Four-way select:
  - Stimulus: NUM_MSG=4, messages={5,6,7,8}, sel=3, N=13, rand_val=1.
  - Expect: result=7.
  - Then start pulsed in cycle 10: ignored, and result is still 7.
- Errors, with UNPACK_ERR_CHECK_EN defined:
  - N=0 → err=1, result=0, done at cycle 1.
  - Without the macro, N=0, m'=5, rand_val=9 → result=0xFFFFFFFC.
- Reset mid-operation:
  - Stimulus: assert rstn=0 in cycle 20.
  - Expect: busy=0, no done pulse, result=0.
  - A fresh request afterwards completes with the correct value.
